// File: rtl/instr_decode_stage.sv
`default_nettype none
// ============================================================================
// Module  : instr_decode_stage
// Brief   : Registered RV32I/RV64I decode stage with 2-entry skid buffer.
// Revision: 1.0
// ============================================================================
module instr_decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    generate
        if ((XLEN != 32) && (XLEN != 64)) begin : g_xlen_check
            $error("instr_decode_stage: XLEN must be 32 or 64");
        end
    endgenerate

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_UNK = 3'd7;

    logic [1:0]      state_q, state_d;
    logic            in_ready_q;
    logic            w_accept, w_pop;
    logic            w_ld_main_in, w_ld_main_skid, w_ld_skid_in;

    logic [2:0]      w_fmt;
    logic [XLEN-1:0] w_imm;
    logic            w_ill;

    logic [PC_W-1:0] main_pc_q,    skid_pc_q;
    logic [31:0]     main_instr_q, skid_instr_q;
    logic [XLEN-1:0] main_imm_q,   skid_imm_q;
    logic [2:0]      main_fmt_q,   skid_fmt_q;
    logic            main_ill_q,   skid_ill_q;

    assign out_valid = (state_q != S_EMPTY);
    assign in_ready  = in_ready_q;
    assign w_accept  = in_valid & in_ready_q;
    assign w_pop     = out_valid & out_ready;

    // Immediates are formed as signed values and size-cast so XLEN=64 sign-extends.
    always_comb begin
        w_fmt = FMT_UNK;
        w_imm = '0;
        w_ill = 1'b0;
        case (in_instr[6:0])
            OP_OP: w_fmt = FMT_R;
            OP_OPIMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
                w_fmt = FMT_I;
                w_imm = XLEN'($signed(in_instr[31:20]));
            end
            OP_STORE: begin
                w_fmt = FMT_S;
                w_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            end
            OP_BRANCH: begin
                w_fmt = FMT_B;
                w_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                       in_instr[11:8], 1'b0}));
            end
            OP_LUI, OP_AUIPC: begin
                w_fmt = FMT_U;
                w_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
            end
            OP_JAL: begin
                w_fmt = FMT_J;
                w_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                       in_instr[30:21], 1'b0}));
            end
            default: begin
                w_fmt = FMT_UNK;
                w_ill = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d        = state_q;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid_in   = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (w_accept) begin
                    state_d      = S_ONE;
                    w_ld_main_in = 1'b1;
                end
            end
            S_ONE: begin
                if (w_accept && w_pop) begin
                    w_ld_main_in = 1'b1;
                end else if (w_accept) begin
                    state_d      = S_FULL;
                    w_ld_skid_in = 1'b1;
                end else if (w_pop) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_pop) begin
                    state_d        = S_ONE;
                    w_ld_main_skid = 1'b1;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        // A redirect voids any same-cycle accept or pop.
        if (flush) begin
            state_d        = S_EMPTY;
            w_ld_main_in   = 1'b0;
            w_ld_main_skid = 1'b0;
            w_ld_skid_in   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_EMPTY;
            in_ready_q   <= 1'b1;
            main_pc_q    <= '0;
            main_instr_q <= '0;
            main_imm_q   <= '0;
            main_fmt_q   <= '0;
            main_ill_q   <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_imm_q   <= '0;
            skid_fmt_q   <= '0;
            skid_ill_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != S_FULL);
            if (w_ld_main_in) begin
                main_pc_q    <= in_pc;
                main_instr_q <= in_instr;
                main_imm_q   <= w_imm;
                main_fmt_q   <= w_fmt;
                main_ill_q   <= w_ill;
            end else if (w_ld_main_skid) begin
                main_pc_q    <= skid_pc_q;
                main_instr_q <= skid_instr_q;
                main_imm_q   <= skid_imm_q;
                main_fmt_q   <= skid_fmt_q;
                main_ill_q   <= skid_ill_q;
            end
            if (w_ld_skid_in) begin
                skid_pc_q    <= in_pc;
                skid_instr_q <= in_instr;
                skid_imm_q   <= w_imm;
                skid_fmt_q   <= w_fmt;
                skid_ill_q   <= w_ill;
            end
        end
    end

    assign out_pc      = main_pc_q;
    assign out_opcode  = main_instr_q[6:0];
    assign out_rd      = main_instr_q[11:7];
    assign out_funct3  = main_instr_q[14:12];
    assign out_rs1     = main_instr_q[19:15];
    assign out_rs2     = main_instr_q[24:20];
    assign out_funct7  = main_instr_q[31:25];
    assign out_imm     = main_imm_q;
    assign out_fmt     = main_fmt_q;
    assign out_illegal = main_ill_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_decode_stage
// Brief   : Directed and randomized checks of instr_decode_stage against a queue model.
// Revision: 1.0
// ============================================================================
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [6:0]  out_funct7;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;

    logic        v_in_valid = 1'b0;
    logic        v_in_ready;
    logic [31:0] v_in_instr = '0;
    logic [31:0] v_in_pc = '0;
    logic        v_out_valid;
    logic [31:0] v_out_pc;
    logic [6:0]  v_out_opcode;
    logic [4:0]  v_out_rd;
    logic [2:0]  v_out_funct3;
    logic [4:0]  v_out_rs1;
    logic [4:0]  v_out_rs2;
    logic [6:0]  v_out_funct7;
    logic [63:0] v_out_imm;
    logic [2:0]  v_out_fmt;
    logic        v_out_illegal;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    always #5 clk = ~clk;

    instr_decode_stage #(.XLEN(32), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct7(out_funct7),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
    );

    instr_decode_stage #(.XLEN(64), .PC_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v_in_valid), .in_ready(v_in_ready), .in_instr(v_in_instr), .in_pc(v_in_pc),
        .flush(1'b0),
        .out_valid(v_out_valid), .out_ready(1'b1), .out_pc(v_out_pc),
        .out_opcode(v_out_opcode), .out_rd(v_out_rd), .out_funct3(v_out_funct3),
        .out_rs1(v_out_rs1), .out_rs2(v_out_rs2), .out_funct7(v_out_funct7),
        .out_imm(v_out_imm), .out_fmt(v_out_fmt), .out_illegal(v_out_illegal)
    );

    // Two's-complement interpretation of an n-bit unsigned field.
    function automatic longint sext(input longint val, input int n);
        longint half, full;
        half = longint'(1) << (n - 1);
        full = longint'(1) << n;
        return (val >= half) ? val - full : val;
    endfunction

    function automatic void ref_dec(input logic [31:0] i, output logic [2:0] fmt,
                                    output logic [63:0] imm, output logic ill);
        longint v;
        v   = 0;
        fmt = 3'd7;
        ill = 1'b1;
        case (i[6:0])
            7'h33: begin fmt = 3'd0; ill = 1'b0; end
            7'h13, 7'h03, 7'h67, 7'h73: begin
                fmt = 3'd1; ill = 1'b0;
                v = sext(longint'(i[31:20]), 12);
            end
            7'h23: begin
                fmt = 3'd2; ill = 1'b0;
                v = sext(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12);
            end
            7'h63: begin
                fmt = 3'd3; ill = 1'b0;
                v = sext(longint'(i[31]) * 4096 + longint'(i[7]) * 2048
                         + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2, 13);
            end
            7'h37, 7'h17: begin
                fmt = 3'd4; ill = 1'b0;
                v = sext(longint'(i[31:12]), 20) * 4096;
            end
            7'h6F: begin
                fmt = 3'd5; ill = 1'b0;
                v = sext(longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096
                         + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2, 21);
            end
            default: ;
        endcase
        imm = 64'(v);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs: valid=%b ready=%b, want valid=0 ready=1", out_valid, in_ready);
        end
        checks++;
        if ({out_pc, out_opcode, out_rd, out_funct3, out_rs1, out_rs2, out_funct7,
             out_imm, out_fmt, out_illegal} !== '0) begin
            errors++;
            $display("FAIL reset_data: pc=%h imm=%h fmt=%0d ill=%b, want all zero",
                     out_pc, out_imm, out_fmt, out_illegal);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_addi();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        in_pc     = 32'h0000_0100;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_rd !== 5'd1 || out_rs1 !== 5'd0 || out_fmt !== 3'd1
            || out_imm !== 32'hFFFFFFFF || out_illegal !== 1'b0 || out_pc !== 32'h100) begin
            errors++;
            $display("FAIL addi: v=%b rd=%0d rs1=%0d fmt=%0d imm=%h ill=%b pc=%h, want 1 1 0 1 ffffffff 0 100",
                     out_valid, out_rd, out_rs1, out_fmt, out_imm, out_illegal, out_pc);
        end
        @(negedge clk);
    endtask

    task automatic test_store_branch();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h00112623;
        in_pc     = 32'h200;
        @(negedge clk);
        in_instr = 32'hFE000EE3;
        in_pc    = 32'h204;
        checks++;
        if (out_fmt !== 3'd2 || out_rs1 !== 5'd2 || out_rs2 !== 5'd1 || out_imm !== 32'd12) begin
            errors++;
            $display("FAIL sw: fmt=%0d rs1=%0d rs2=%0d imm=%h, want 2 2 1 0000000c",
                     out_fmt, out_rs1, out_rs2, out_imm);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_fmt !== 3'd3 || out_imm !== 32'hFFFFFFFC || out_pc !== 32'h204) begin
            errors++;
            $display("FAIL beq: v=%b fmt=%0d imm=%h pc=%h, want 1 3 fffffffc 204",
                     out_valid, out_fmt, out_imm, out_pc);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093;
        in_pc     = 32'h1000;
        @(negedge clk);
        in_instr = 32'h00200093;
        in_pc    = 32'h1004;
        checks++;
        if (in_ready !== 1'b1 || out_pc !== 32'h1000) begin
            errors++;
            $display("FAIL bp_a: ready=%b pc=%h, want 1 1000", in_ready, out_pc);
        end
        @(negedge clk);
        in_instr = 32'h00300093;
        in_pc    = 32'h1008;
        checks++;
        if (in_ready !== 1'b0 || out_pc !== 32'h1000 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_full: ready=%b valid=%b pc=%h, want 0 1 1000", in_ready, out_valid, out_pc);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_pc !== 32'h1000 || out_rd !== 5'd1) begin
            errors++;
            $display("FAIL bp_hold: ready=%b pc=%h rd=%0d, want 0 1000 1", in_ready, out_pc, out_rd);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h1004 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_b: valid=%b pc=%h ready=%b, want 1 1004 1", out_valid, out_pc, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h1008 || out_rd !== 5'd1) begin
            errors++;
            $display("FAIL bp_c: valid=%b pc=%h rd=%0d, want 1 1008 1", out_valid, out_pc, out_rd);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_flush_full();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093;
        in_pc     = 32'h3000;
        @(negedge clk);
        in_pc = 32'h3004;
        @(negedge clk);
        in_pc = 32'h3008;
        flush = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush: valid=%b ready=%b, want 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop: valid=%b pc=%h, want no output", out_valid, out_pc);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] pats [2];
        pats[0] = 32'h00000000;
        pats[1] = 32'h0000007F;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_instr = pats[k];
            in_pc    = 32'h4000 + 32'(k * 4);
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_fmt !== 3'd7 || out_imm !== 32'd0
                || out_opcode !== pats[k][6:0]) begin
                errors++;
                $display("FAIL illegal%0d: v=%b ill=%b fmt=%0d imm=%h op=%h, want 1 1 7 0", k,
                         out_valid, out_illegal, out_fmt, out_imm, out_opcode);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_xlen64();
        v_in_valid = 1'b1;
        v_in_instr = 32'h800000B7;
        v_in_pc    = 32'h5000;
        @(negedge clk);
        v_in_valid = 1'b0;
        checks++;
        if (v_out_valid !== 1'b1 || v_out_imm !== 64'hFFFFFFFF80000000 || v_out_fmt !== 3'd4
            || v_out_rd !== 5'd1) begin
            errors++;
            $display("FAIL lui64: v=%b imm=%h fmt=%0d rd=%0d, want 1 ffffffff80000000 4 1",
                     v_out_valid, v_out_imm, v_out_fmt, v_out_rd);
        end
        v_in_valid = 1'b1;
        v_in_instr = 32'hFE000EE3;
        @(negedge clk);
        v_in_valid = 1'b0;
        checks++;
        if (v_out_imm !== 64'hFFFFFFFFFFFFFFFC || v_out_fmt !== 3'd3) begin
            errors++;
            $display("FAIL beq64: imm=%h fmt=%0d, want fffffffffffffffc 3", v_out_imm, v_out_fmt);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        in_pc     = 32'h6000;
        @(negedge clk);
        in_pc = 32'h6004;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'd0 || out_imm !== 32'd0
            || out_opcode !== 7'd0 || out_fmt !== 3'd0 || out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_full: v=%b rdy=%b pc=%h imm=%h op=%h fmt=%0d ill=%b, want 0 1 0 0 0 0 0",
                     out_valid, in_ready, out_pc, out_imm, out_opcode, out_fmt, out_illegal);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_drop: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_random();
        ent_t        q[$];
        ent_t        e;
        logic [6:0]  legal [10];
        logic [2:0]  e_fmt;
        logic [63:0] e_imm;
        logic        e_ill;
        logic [31:0] r;
        bit          acc, pop;
        legal = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        for (int cyc = 0; cyc < 600; cyc++) begin
            checks++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                errors++;
                $display("FAIL rnd_hs cyc=%0d: valid=%b ready=%b, want %b %b", cyc,
                         out_valid, in_ready, q.size() > 0, q.size() < 2);
            end
            if (q.size() > 0) begin
                ref_dec(q[0].instr, e_fmt, e_imm, e_ill);
                checks++;
                if (out_pc !== q[0].pc || out_opcode !== q[0].instr[6:0] || out_rd !== q[0].instr[11:7]
                    || out_funct3 !== q[0].instr[14:12] || out_rs1 !== q[0].instr[19:15]
                    || out_rs2 !== q[0].instr[24:20] || out_funct7 !== q[0].instr[31:25]
                    || out_imm !== e_imm[31:0] || out_fmt !== e_fmt || out_illegal !== e_ill) begin
                    errors++;
                    $display("FAIL rnd_data cyc=%0d: pc=%h op=%h imm=%h fmt=%0d ill=%b, want pc=%h instr=%h imm=%h fmt=%0d ill=%b",
                             cyc, out_pc, out_opcode, out_imm, out_fmt, out_illegal,
                             q[0].pc, q[0].instr, e_imm[31:0], e_fmt, e_ill);
                end
            end
            r         = $urandom;
            in_valid  = ($urandom_range(3) != 0);
            in_instr  = (($urandom_range(12) < 10) ? {r[31:7], legal[$urandom_range(9)]} : r);
            in_pc     = $urandom;
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(39) == 0);
            acc = in_valid && (q.size() < 2);
            pop = out_ready && (q.size() > 0);
            e.instr = in_instr;
            e.pc    = in_pc;
            @(posedge clk);
            if (flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_store_branch();
        test_back_to_back();
        test_flush_full();
        test_illegal();
        test_xlen64();
        test_reset_full();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
